// File: rtl/decode_stage.sv
// RV32I decode for integer-computational instructions into ALU op/operands.
// One-entry registered output slot; latency 1 cycle; in_ready = !out_valid || out_ready; flush wins.
module decode_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_operand1,
  output logic [31:0] out_operand2,
  output logic [3:0]  out_alu_op,
  output logic [4:0]  out_rd,
  output logic        out_reg_write,
  output logic        out_illegal,
  output logic [31:0] out_pc
);

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLL  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_SLT  = 4'b1000,
    ALU_SLTU = 4'b1001
  } alu_op_e;

  typedef struct packed {
    logic [31:0] operand1;
    logic [31:0] operand2;
    alu_op_e     alu_op;
    logic [4:0]  rd;
    logic        reg_write;
    logic        illegal;
    logic [31:0] pc;
  } slot_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] F7_ZERO    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i;
  logic [31:0] imm_u;
  logic [31:0] shamt;
  logic        f7_zero;
  logic        f7_alt;

  assign opcode  = in_instr[6:0];
  assign funct3  = in_instr[14:12];
  assign funct7  = in_instr[31:25];
  assign imm_i   = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_u   = {in_instr[31:12], 12'b0};
  assign shamt   = {27'b0, in_instr[24:20]};
  assign f7_zero = (funct7 == F7_ZERO);
  assign f7_alt  = (funct7 == F7_ALT);

  assign rs1_addr = in_instr[19:15];
  assign rs2_addr = in_instr[24:20];

  // funct3 -> ALU op shared by R-type and I-type; SUB/SRA selected by caller.
  function automatic alu_op_e f3_to_op(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  slot_t dec;
  logic  legal;

  always_comb begin
    legal        = 1'b0;
    dec          = '0;
    dec.alu_op   = ALU_ADD;
    dec.rd       = in_instr[11:7];
    dec.pc       = in_pc;
    case (opcode)
      OPC_OP: begin
        dec.operand1 = rs1_data;
        dec.operand2 = rs2_data;
        dec.alu_op   = f3_to_op(funct3, f7_alt);
        legal        = f7_zero || (f7_alt && (funct3 == 3'b000 || funct3 == 3'b101));
      end
      OPC_OP_IMM: begin
        dec.operand1 = rs1_data;
        dec.operand2 = imm_i;
        dec.alu_op   = f3_to_op(funct3, 1'b0);
        legal        = 1'b1;
        if (funct3 == 3'b001) begin
          dec.operand2 = shamt;
          legal        = f7_zero;
        end else if (funct3 == 3'b101) begin
          dec.operand2 = shamt;
          dec.alu_op   = f3_to_op(funct3, f7_alt);
          legal        = f7_zero || f7_alt;
        end
      end
      OPC_LUI: begin
        dec.operand2 = imm_u;
        legal        = 1'b1;
      end
      OPC_AUIPC: begin
        dec.operand1 = in_pc;
        dec.operand2 = imm_u;
        legal        = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    // Illegal encodings still occupy the slot so execute can trap on them.
    if (!legal) begin
      dec.operand1 = '0;
      dec.operand2 = '0;
      dec.alu_op   = ALU_ADD;
    end
    dec.illegal   = !legal;
    dec.reg_write = legal && (dec.rd != 5'd0);
  end

  slot_t slot_q, slot_d;
  logic  valid_q, valid_d;
  logic  accept;
  logic  consume;

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;
  assign consume  = valid_q && out_ready;

  always_comb begin
    slot_d  = slot_q;
    valid_d = valid_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      slot_d  = dec;
      valid_d = 1'b1;
    end else if (consume) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      slot_q  <= slot_d;
      valid_q <= valid_d;
    end
  end

  assign out_valid     = valid_q;
  assign out_operand1  = slot_q.operand1;
  assign out_operand2  = slot_q.operand2;
  assign out_alu_op    = slot_q.alu_op;
  assign out_rd        = slot_q.rd;
  assign out_reg_write = slot_q.reg_write;
  assign out_illegal   = slot_q.illegal;
  assign out_pc        = slot_q.pc;

endmodule

// File: tb/tb_decode_stage.sv
// Directed-vector bench for decode_stage with hand-computed expectations.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_operand1;
  logic [31:0] out_operand2;
  logic [3:0]  out_alu_op;
  logic [4:0]  out_rd;
  logic        out_reg_write;
  logic        out_illegal;
  logic [31:0] out_pc;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_instr      (in_instr),
    .in_pc         (in_pc),
    .rs1_addr      (rs1_addr),
    .rs2_addr      (rs2_addr),
    .rs1_data      (rs1_data),
    .rs2_data      (rs2_data),
    .flush         (flush),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_operand1  (out_operand1),
    .out_operand2  (out_operand2),
    .out_alu_op    (out_alu_op),
    .out_rd        (out_rd),
    .out_reg_write (out_reg_write),
    .out_illegal   (out_illegal),
    .out_pc        (out_pc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %08h want %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_slot(input string tag, input logic [31:0] op1, input logic [31:0] op2,
                          input logic [3:0] op, input logic [4:0] rd, input logic rw,
                          input logic ill, input logic [31:0] pc);
    chk({tag, ".valid"}, {31'b0, out_valid}, 32'd1);
    chk({tag, ".op1"}, out_operand1, op1);
    chk({tag, ".op2"}, out_operand2, op2);
    chk({tag, ".alu"}, {28'b0, out_alu_op}, {28'b0, op});
    chk({tag, ".rd"}, {27'b0, out_rd}, {27'b0, rd});
    chk({tag, ".rw"}, {31'b0, out_reg_write}, {31'b0, rw});
    chk({tag, ".ill"}, {31'b0, out_illegal}, {31'b0, ill});
    chk({tag, ".pc"}, out_pc, pc);
  endtask

  // Streams one instruction with out_ready high and checks the slot one edge later.
  task automatic apply(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] r1, input logic [31:0] r2,
                       input logic [31:0] op1, input logic [31:0] op2,
                       input logic [3:0] op, input logic [4:0] rd, input logic rw,
                       input logic ill);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_instr  = instr;
    in_pc     = pc;
    rs1_data  = r1;
    rs2_data  = r2;
    tick();
    chk_slot(tag, op1, op2, op, rd, rw, ill, pc);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0;
    rs1_data = '0; rs2_data = '0; flush = 1'b0; out_ready = 1'b0;
    tick();
    chk("rst.in_ready", {31'b0, in_ready}, 32'd1);
    tick();
    chk("rst.valid", {31'b0, out_valid}, 32'd0);
    chk("rst.alu", {28'b0, out_alu_op}, 32'd0);
    chk("rst.op1", out_operand1, 32'd0);
    chk("rst.op2", out_operand2, 32'd0);
    chk("rst.pc", out_pc, 32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst.in_ready", {31'b0, in_ready}, 32'd1);

    // ADD x3,x1,x2 loaded with execute stalled
    in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 32'h0000_0040;
    rs1_data = 32'd1; rs2_data = 32'd2; out_ready = 1'b0;
    #1;
    chk("add.rs1_addr", {27'b0, rs1_addr}, 32'd1);
    chk("add.rs2_addr", {27'b0, rs2_addr}, 32'd2);
    tick();
    chk_slot("add", 32'd1, 32'd2, 4'b0000, 5'd3, 1'b1, 1'b0, 32'h40);

    // Next instruction (SUB x4,x1,x2) waits three stalled cycles
    in_instr = 32'h40208233; in_pc = 32'h0000_0044; rs1_data = 32'd10; rs2_data = 32'd3;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall.in_ready", {31'b0, in_ready}, 32'd0);
      chk_slot("stall", 32'd1, 32'd2, 4'b0000, 5'd3, 1'b1, 1'b0, 32'h40);
    end
    out_ready = 1'b1;
    #1;
    chk("release.in_ready", {31'b0, in_ready}, 32'd1);
    tick();
    chk_slot("sub", 32'd10, 32'd3, 4'b0001, 5'd4, 1'b1, 1'b0, 32'h44);

    //     tag      instr         pc            rs1           rs2           op1           op2           alu      rd   rw ill
    apply("srai",  32'h4020D313, 32'h48,       32'h80000000, 32'h0,        32'h80000000, 32'h2,        4'b0111, 5'd6, 1, 0);
    apply("addi",  32'hFFF00293, 32'h4C,       32'h0,        32'h0,        32'h0,        32'hFFFFFFFF, 4'b0000, 5'd5, 1, 0);
    apply("lui",   32'h123453B7, 32'h50,       32'h55,       32'h66,       32'h0,        32'h12345000, 4'b0000, 5'd7, 1, 0);
    apply("auipc", 32'h00001417, 32'h100,      32'h55,       32'h66,       32'h100,      32'h1000,     4'b0000, 5'd8, 1, 0);
    apply("ecall", 32'h00000073, 32'h104,      32'h55,       32'h66,       32'h0,        32'h0,        4'b0000, 5'd0, 0, 1);
    apply("f7bad", 32'h022081B3, 32'h108,      32'h55,       32'h66,       32'h0,        32'h0,        4'b0000, 5'd3, 0, 1);
    apply("nop",   32'h00000013, 32'h10C,      32'h0,        32'h0,        32'h0,        32'h0,        4'b0000, 5'd0, 0, 0);
    apply("slt",   32'h0020A4B3, 32'h110,      32'h7,        32'h9,        32'h7,        32'h9,        4'b1000, 5'd9, 1, 0);
    apply("sltiu", 32'hFFE0B513, 32'h114,      32'h3,        32'h0,        32'h3,        32'hFFFFFFFE, 4'b1001, 5'd10, 1, 0);
    apply("slli7", 32'h40209313, 32'h118,      32'h3,        32'h4,        32'h0,        32'h0,        4'b0000, 5'd6, 0, 1);
    apply("andalt",32'h4020F1B3, 32'h11C,      32'h3,        32'h4,        32'h0,        32'h0,        4'b0000, 5'd3, 0, 1);
    apply("or",    32'h0020E1B3, 32'h120,      32'hF0,       32'h0F,       32'hF0,       32'h0F,       4'b0011, 5'd3, 1, 0);

    // Consume with nothing incoming empties the slot
    in_valid = 1'b0;
    tick();
    chk("drain.valid", {31'b0, out_valid}, 32'd0);

    // Flush on a stalled slot while fetch presents a new instruction
    in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 32'h200; out_ready = 1'b0;
    tick();
    chk("fl.load", {31'b0, out_valid}, 32'd1);
    flush = 1'b1; in_instr = 32'h123453B7; in_pc = 32'h204;
    tick();
    chk("fl.valid", {31'b0, out_valid}, 32'd0);
    flush = 1'b0; in_valid = 1'b0;
    tick();
    chk("fl.not_loaded", {31'b0, out_valid}, 32'd0);

    // Flush with an empty slot blocks the accept
    flush = 1'b1; in_valid = 1'b1;
    #1;
    chk("fl2.in_ready", {31'b0, in_ready}, 32'd1);
    tick();
    chk("fl2.valid", {31'b0, out_valid}, 32'd0);
    flush = 1'b0; in_valid = 1'b0;

    // Reset in the middle of a stall
    in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 32'h300; rs1_data = 32'd1; rs2_data = 32'd2;
    tick();
    in_valid = 1'b0;
    tick();
    chk("rs.stalled", {31'b0, in_ready}, 32'd0);
    rst = 1'b1;
    tick();
    chk("rs.valid", {31'b0, out_valid}, 32'd0);
    chk("rs.in_ready", {31'b0, in_ready}, 32'd1);
    chk("rs.op1", out_operand1, 32'd0);
    chk("rs.rd", {27'b0, out_rd}, 32'd0);
    rst = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
